// File: rtl/prog_ram_loader.sv
// Boot-loaded program/data RAM for projectCPU2020: streams loader words from address 0, then releases the CPU.
// Registered read port (1-cycle latency, read-before-write). Optional MMIO_OUT_EN maps address DEPTH-1 to io_out.
module prog_ram_loader #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_done,
    output logic              cpu_rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_wrEn,
    output logic [DATA_W-1:0] cpu_rdata
`ifdef MMIO_OUT_EN
    ,
    output logic [DATA_W-1:0] io_out
`endif
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] wptr_q;
    logic [ADDR_W-1:0] wptr_d;
    logic              load_ready_q;
    logic              load_done_q;
    logic              cpu_rst_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              load_acc;
    logic              cpu_we;
    logic              io_hit;
    logic              ram_cpu_we;

    assign wptr_d   = wptr_q + 1'b1;
    assign load_acc = !rst && load_ready_q && load_valid;
    assign cpu_we   = !rst && (state_q == ST_RUN) && cpu_wrEn;

`ifdef MMIO_OUT_EN
    logic [DATA_W-1:0] io_q;

    assign io_hit = (cpu_addr == LAST_ADDR);

    // io_out only follows CPU writes; the loader never touches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_q <= '0;
        end else if (cpu_we && io_hit) begin
            io_q <= cpu_wdata;
        end
    end

    assign io_out = io_q;
`else
    assign io_hit = 1'b0;
`endif

    assign ram_cpu_we = cpu_we && !io_hit;

    // No reset on the array so it maps onto block RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (load_acc) begin
            mem_q[wptr_q] <= load_data;
        end else if (ram_cpu_we) begin
            mem_q[cpu_addr] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata_q <= '0;
        end else if (state_q == ST_RUN) begin
`ifdef MMIO_OUT_EN
            cpu_rdata_q <= io_hit ? io_q : mem_q[cpu_addr];
`else
            cpu_rdata_q <= mem_q[cpu_addr];
`endif
        end else begin
            cpu_rdata_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            wptr_q       <= '0;
            load_ready_q <= 1'b1;
            load_done_q  <= 1'b0;
            cpu_rst_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (load_acc) begin
                        if (load_last || (wptr_q == LAST_ADDR)) begin
                            state_q      <= ST_FLUSH;
                            wptr_q       <= '0;
                            load_ready_q <= 1'b0;
                        end else begin
                            wptr_q <= wptr_d;
                        end
                    end
                end
                // One dead cycle so the final loader write lands before the CPU fetches.
                ST_FLUSH: begin
                    state_q     <= ST_RUN;
                    cpu_rst_q   <= 1'b0;
                    load_done_q <= 1'b1;
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q      <= ST_LOAD;
                    wptr_q       <= '0;
                    load_ready_q <= 1'b1;
                    load_done_q  <= 1'b0;
                    cpu_rst_q    <= 1'b1;
                end
            endcase
        end
    end

    assign load_ready = load_ready_q;
    assign load_done  = load_done_q;
    assign cpu_rst    = cpu_rst_q;
    assign cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_prog_ram_loader.sv
// Randomized scoreboard bench for prog_ram_loader: reference memory model, read responses checked by a monitor.
module tb_prog_ram_loader;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_valid = 1'b0;
    logic              load_ready;
    logic [DATA_W-1:0] load_data = '0;
    logic              load_last = 1'b0;
    logic              load_done;
    logic              cpu_rst;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_wrEn = 1'b0;
    logic [DATA_W-1:0] cpu_rdata;
`ifdef MMIO_OUT_EN
    logic [DATA_W-1:0] io_out;
`endif

    prog_ram_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_done  (load_done),
        .cpu_rst    (cpu_rst),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_wrEn   (cpu_wrEn),
        .cpu_rdata  (cpu_rdata)
`ifdef MMIO_OUT_EN
        ,
        .io_out     (io_out)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: what each address should hold, and which addresses have a defined value.
    logic [DATA_W-1:0] m_mem   [DEPTH];
    bit                m_known [DEPTH];
    int                m_wptr = 0;
    logic [DATA_W-1:0] m_io = '0;

    logic [DATA_W-1:0] exp_q [$];
    logic              rd_req = 1'b0;
    logic              rsp_vld = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_io(input int a);
`ifdef MMIO_OUT_EN
        return a == DEPTH - 1;
`else
        return a < 0;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] exp_read(input int a);
        if (is_io(a)) return m_io;
        return m_mem[a];
    endfunction

    always @(posedge clk) rsp_vld <= rd_req;

    always @(negedge clk) begin
        if (rsp_vld) begin
            if (exp_q.size() == 0) chk("rdata_unexpected", 32'(cpu_rdata), 32'hFFFF_FFFF);
            else chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_q.pop_front()));
        end
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; load_valid = 1'b0; load_last = 1'b0; cpu_wrEn = 1'b0; rd_req = 1'b0;
        repeat (n) @(negedge clk);
        m_wptr = 0; m_io = '0;
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_load_done", 32'(load_done), 32'd0);
        rst = 1'b0;
    endtask

    // Drive one loader word for one cycle; returns at the negedge after the accepting posedge.
    task automatic send(input logic [DATA_W-1:0] d, input bit last, input bit chk_rdy);
        load_valid = 1'b1; load_data = d; load_last = last;
        if (chk_rdy) chk("load_ready_in_load", 32'(load_ready), 32'd1);
        @(negedge clk);
        load_valid = 1'b0; load_last = 1'b0; load_data = DATA_W'($urandom);
        m_mem[m_wptr] = d;
        m_known[m_wptr] = 1'b1;
        m_wptr = (last || m_wptr == DEPTH - 1) ? 0 : m_wptr + 1;
    endtask

    // Called right after the final word's accept edge T: FLUSH now, RUN after edge T+1.
    task automatic finish_check();
        chk("flush_load_ready", 32'(load_ready), 32'd0);
        chk("flush_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("flush_load_done", 32'(load_done), 32'd0);
        @(negedge clk);
        chk("run_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("run_load_done", 32'(load_done), 32'd1);
        chk("run_load_ready", 32'(load_ready), 32'd0);
    endtask

    task automatic cpu_cycle(input int a, input bit we, input logic [DATA_W-1:0] wd);
        cpu_addr = ADDR_W'(a); cpu_wrEn = we; cpu_wdata = wd;
        rd_req = m_known[a] || is_io(a);
        if (rd_req) exp_q.push_back(exp_read(a));
        if (we) begin
            if (is_io(a)) m_io = wd;
            else begin
                m_mem[a] = wd;
                m_known[a] = 1'b1;
            end
        end
        @(negedge clk);
        cpu_wrEn = 1'b0; rd_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

        // Reset state, and CPU port ignored while loading.
        do_reset(2);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);

        // Boot sequence.
        send(16'hA005, 1'b0, 1'b1);
        send(16'h0007, 1'b0, 1'b1);
        send(16'h1234, 1'b1, 1'b1);
        finish_check();
        cpu_cycle(1, 1'b0, '0);
        cpu_cycle(0, 1'b0, '0);
        cpu_cycle(2, 1'b0, '0);

        // Loader gaps; CPU write attempts during LOAD must not land.
        do_reset(1);
        send(16'h1111, 1'b0, 1'b1);
        cpu_addr = 13'd2; cpu_wrEn = 1'b1; cpu_wdata = 16'hFFFF;
        repeat (2) begin
            load_data = DATA_W'($urandom);
            @(negedge clk);
            chk("gap_cpu_rdata", 32'(cpu_rdata), 32'd0);
        end
        cpu_wrEn = 1'b0;
        send(16'h2222, 1'b1, 1'b1);
        finish_check();
        cpu_cycle(0, 1'b0, '0);
        cpu_cycle(1, 1'b0, '0);
        cpu_cycle(2, 1'b0, '0);

        // Read-before-write on one address.
        cpu_cycle(16, 1'b1, 16'h0A0A);
        cpu_cycle(16, 1'b1, 16'hBEEF);
        cpu_cycle(16, 1'b0, '0);

        // Random CPU traffic on a small window; stray loader pulses must be ignored.
        for (int i = 0; i < 200; i++) begin
            load_valid = 1'($urandom);
            load_data  = DATA_W'($urandom);
            if (i % 20 == 0) chk("run_ready_low", 32'(load_ready), 32'd0);
            cpu_cycle($urandom_range(0, 31), 1'($urandom), DATA_W'($urandom));
        end
        load_valid = 1'b0;

        // Random-length load with random gaps.
        do_reset(1);
        begin
            int n;
            n = $urandom_range(3, 12);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(DATA_W'($urandom), i == n - 1, 1'b1);
            end
            finish_check();
            for (int i = 0; i < n + 2; i++) cpu_cycle(i, 1'b0, '0);
        end

        // Reset in the middle of a load.
        do_reset(1);
        send(DATA_W'($urandom), 1'b0, 1'b1);
        send(DATA_W'($urandom), 1'b0, 1'b1);
        do_reset(1);
        chk("midload_cpu_rst", 32'(cpu_rst), 32'd1);
        send(16'h5555, 1'b1, 1'b1);
        finish_check();
        cpu_cycle(0, 1'b0, '0);
        cpu_cycle(1, 1'b0, '0);

        // Full-depth load without last: automatic flush after word DEPTH-1.
        do_reset(1);
        for (int i = 0; i < DEPTH - 1; i++) send(DATA_W'($urandom), 1'b0, 1'b0);
        chk("wrap_cpu_rst_before_last", 32'(cpu_rst), 32'd1);
        send(DATA_W'($urandom), 1'b0, 1'b1);
        finish_check();
        load_valid = 1'b1; load_data = 16'hDEAD; load_last = 1'b1;
        @(negedge clk);
        load_valid = 1'b0; load_last = 1'b0;
        chk("wrap_pulse_cpu_rst", 32'(cpu_rst), 32'd0);
        cpu_cycle(0, 1'b0, '0);
        cpu_cycle(1, 1'b0, '0);
        cpu_cycle(DEPTH - 2, 1'b0, '0);
        cpu_cycle(DEPTH - 1, 1'b0, '0);

`ifdef MMIO_OUT_EN
        cpu_cycle(DEPTH - 1, 1'b1, 16'h00C3);
        chk("io_out", 32'(io_out), 32'h00C3);
        cpu_cycle(DEPTH - 1, 1'b0, '0);
        cpu_cycle(DEPTH - 2, 1'b0, '0);
`endif

        // Drain outstanding responses with a bound.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
